// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants: default 640x480 timing, text-cell geometry and
// position widths used by vga_sync_gen and vga_axis_counter.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CELL_W = 8;
    localparam int CELL_H = 16;

    localparam int H_POS_W = 11;
    localparam int V_POS_W = 10;

    function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with enable, plus sync-window and active-window
// decode taken from the next count so registered outputs carry no extra latency.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = axisTotal(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP),
    parameter int WIDTH      = H_POS_W,
    parameter int ACTIVE     = DEF_H_ACTIVE,
    parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
    parameter int SYNC_LEN   = DEF_H_SYNC
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    output logic [WIDTH-1:0] pos,
    output logic [WIDTH-1:0] posNext,
    output logic             atEnd,
    output logic             syncN,
    output logic             activeNext
);

    localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] SYNC_FIRST = WIDTH'(SYNC_START);
    localparam logic [WIDTH-1:0] SYNC_LAST  = WIDTH'(SYNC_START + SYNC_LEN - 1);
    localparam logic [WIDTH-1:0] ACT_END    = WIDTH'(ACTIVE);

    logic syncNNext;

    assign atEnd = (pos == LAST);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        posNext = pos;
        if (en)
            posNext = atEnd ? '0 : pos + 1'b1;
    end

    assign activeNext = (posNext < ACT_END);
    assign syncNNext  = !((posNext >= SYNC_FIRST) && (posNext <= SYNC_LAST));

    // Reset parks the axis on its last (back-porch) count, so sync is inactive.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pos   <= LAST;
            syncN <= 1'b1;
        end else begin
            pos   <= posNext;
            syncN <= syncNNext;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: hsync/vsync/de, positions and line/frame pulses.
// Define VGA_TEXTCELL_EN to add registered 8x16 text-cell coordinate outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pixEn,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [H_POS_W-1:0] hPos,
    output logic [V_POS_W-1:0] vPos,
    output logic               lineStart,
    output logic               frameStart
`ifdef VGA_TEXTCELL_EN
   ,output logic [6:0]         cellCol,
    output logic [2:0]         glyphX,
    output logic [5:0]         cellRow,
    output logic [3:0]         glyphY
`endif
);

    localparam int H_TOTAL = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [H_POS_W-1:0] hPosNext;
    logic [V_POS_W-1:0] vPosNext;
    logic hAtEnd, vAtEnd, hActiveNext, vActiveNext;
    logic vEn;

    // The vertical axis steps only on the pixel that wraps the line.
    assign vEn = pixEn & hAtEnd;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .WIDTH      (H_POS_W),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC)
    ) hAxis (
        .clk        (clk),
        .resetn     (resetn),
        .en         (pixEn),
        .pos        (hPos),
        .posNext    (hPosNext),
        .atEnd      (hAtEnd),
        .syncN      (hsync),
        .activeNext (hActiveNext)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .WIDTH      (V_POS_W),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC)
    ) vAxis (
        .clk        (clk),
        .resetn     (resetn),
        .en         (vEn),
        .pos        (vPos),
        .posNext    (vPosNext),
        .atEnd      (vAtEnd),
        .syncN      (vsync),
        .activeNext (vActiveNext)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            de         <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            de         <= hActiveNext & vActiveNext;
            lineStart  <= vEn;
            frameStart <= vEn & vAtEnd;
        end
    end

`ifdef VGA_TEXTCELL_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cellCol <= '0;
            glyphX  <= '0;
            cellRow <= '0;
            glyphY  <= '0;
        end else begin
            cellCol <= hPosNext[9:3];
            glyphX  <= hPosNext[2:0];
            cellRow <= {1'b0, vPosNext[8:4]};
            glyphY  <= vPosNext[3:0];
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced raster; the reference model
// derives every output from a linear pixel index within the frame.
module tb_vga_sync_gen;

    localparam int H_ACTIVE = 16, H_FP = 4, H_SYNC = 6, H_BP = 3;
    localparam int V_ACTIVE = 40, V_FP = 3, V_SYNC = 2, V_BP = 2;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [10:0] hPos;
        logic [9:0]  vPos;
        logic        lineStart;
        logic        frameStart;
`ifdef VGA_TEXTCELL_EN
        logic [6:0]  cellCol;
        logic [2:0]  glyphX;
        logic [5:0]  cellRow;
        logic [3:0]  glyphY;
`endif
    } outVec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pixEn = 1'b0;
    logic hsync, vsync, de, lineStart, frameStart;
    logic [10:0] hPos;
    logic [9:0]  vPos;
`ifdef VGA_TEXTCELL_EN
    logic [6:0] cellCol;
    logic [2:0] glyphX;
    logic [5:0] cellRow;
    logic [3:0] glyphY;
`endif

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pixEn      (pixEn),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .hPos       (hPos),
        .vPos       (vPos),
        .lineStart  (lineStart),
        .frameStart (frameStart)
`ifdef VGA_TEXTCELL_EN
       ,.cellCol    (cellCol),
        .glyphX     (glyphX),
        .cellRow    (cellRow),
        .glyphY     (glyphY)
`endif
    );

    outVec_t expQ[$];
    int vectors = 0;
    int miscompares = 0;
    int pixIdx = FT - 1;

    // Reference: position is just the pixel index within the frame.
    function automatic outVec_t expectAt(input int idx, input bit strobe, input bit rst);
        outVec_t e;
        int h, v;
        h = idx % HT;
        v = idx / HT;
        e = '0;
        e.hPos       = 11'(h);
        e.vPos       = 10'(v);
        e.hsync      = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        e.vsync      = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        e.de         = (h < H_ACTIVE) && (v < V_ACTIVE) && !rst;
        e.lineStart  = strobe && (h == 0);
        e.frameStart = strobe && (idx == 0);
`ifdef VGA_TEXTCELL_EN
        if (!rst) begin
            e.cellCol = 7'((h / 8) % 128);
            e.glyphX  = 3'(h % 8);
            e.cellRow = 6'(v / 16);
            e.glyphY  = 4'(v % 16);
        end
`endif
        return e;
    endfunction

    task automatic step(input bit en, input bit rst);
        @(negedge clk);
        pixEn  = en;
        resetn = !rst;
        if (rst)
            pixIdx = FT - 1;
        else if (en)
            pixIdx = (pixIdx + 1) % FT;
        expQ.push_back(expectAt(pixIdx, en && !rst, rst));
    endtask

    // Monitor: one expected vector per clock, compared just after the edge.
    int lineCnt = 0;
    bit primed = 0;
    bit resetSeen = 0;
    always begin
        outVec_t act, exp_v;
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            exp_v = expQ.pop_front();
            act = '0;
            act.hsync = hsync; act.vsync = vsync; act.de = de;
            act.hPos = hPos; act.vPos = vPos;
            act.lineStart = lineStart; act.frameStart = frameStart;
`ifdef VGA_TEXTCELL_EN
            act.cellCol = cellCol; act.glyphX = glyphX;
            act.cellRow = cellRow; act.glyphY = glyphY;
`endif
            vectors++;
            if (act !== exp_v) begin
                miscompares++;
                $display("FAIL vec%0d: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b (%h), want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b (%h)",
                         vectors, act.hPos, act.vPos, act.hsync, act.vsync, act.de, act.lineStart, act.frameStart, act,
                         exp_v.hPos, exp_v.vPos, exp_v.hsync, exp_v.vsync, exp_v.de, exp_v.lineStart, exp_v.frameStart, exp_v);
            end
            if (!resetn) resetSeen = 1;
            if (frameStart) begin
                if (primed && !resetSeen) begin
                    vectors++;
                    if (lineCnt != VT) begin
                        miscompares++;
                        $display("FAIL linesPerFrame: got %0d, want %0d", lineCnt, VT);
                    end
                end
                lineCnt = 1;
                primed = 1;
                resetSeen = 0;
            end else if (lineStart) begin
                lineCnt++;
            end
        end
    end

    initial begin
        int guard;
        step(0, 1);
        step(1, 1);
        step(1, 0);                        // first pixel after reset: (0,0)
        repeat (2 * FT) step(1, 0);
        repeat (FT) begin
            step(1, 0);
            step(0, 0);
        end
        // Reset during the second vsync line, mid-line.
        guard = 0;
        while (pixIdx != (V_ACTIVE + V_FP + 1) * HT + 10 && guard < 2 * FT) begin
            step(1, 0);
            guard++;
        end
        step(1, 1);
        step(0, 0);
        step(1, 0);
        repeat (FT + 200) step(1'($urandom_range(0, 1)), $urandom_range(0, 699) == 0);
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
